// File: rtl/photon_score_aggregator.sv
// Reduces groups of photonic-tile scores to {sum, max, argmax, count} records and buffers them in a show-ahead FIFO.
// Optional build macro PHOTON_AGG_SATURATE_EN: saturating group sum instead of modulo wrap.
module photon_score_aggregator #(
  parameter int KEYS_PER_QUERY = 8,
  parameter int ACC_WIDTH      = 40,
  parameter int FIFO_DEPTH     = 4,
  parameter int IDX_WIDTH      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          score_in,
  input  logic                 score_valid,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [31:0]          out_max,
  output logic [IDX_WIDTH-1:0] out_argmax,
  output logic [IDX_WIDTH:0]   out_count,
  output logic                 credit_ok,
  output logic                 overflow,
  input  logic                 clear_overflow,
  output logic                 dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_WIDTH + 1;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_sum;
  logic [31:0]          r_max;
  logic [IDX_WIDTH-1:0] r_argmax;
  logic [CNT_W-1:0]     r_count;

  logic [ACC_WIDTH-1:0] r_mem_sum [FIFO_DEPTH];
  logic [31:0]          r_mem_max [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0] r_mem_arg [FIFO_DEPTH];
  logic [CNT_W-1:0]     r_mem_cnt [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_entries;
  logic                 r_credit;
  logic                 r_overflow;

  logic [ACC_WIDTH-1:0] w_sum_add;
  logic [ACC_WIDTH-1:0] w_new_sum;
  logic [31:0]          w_new_max;
  logic [IDX_WIDTH-1:0] w_new_arg;
  logic [CNT_W-1:0]     w_new_count;
  logic                 w_gt;
  logic                 w_commit;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [PTR_W:0]       w_entries_next;

`ifdef PHOTON_AGG_SATURATE_EN
  logic [ACC_WIDTH:0]   w_sum_ext;
  assign w_sum_ext = {1'b0, r_sum} + {{(ACC_WIDTH + 1 - 32){1'b0}}, score_in};
  // Once pinned at all-ones, every further add carries out again, so the sum stays saturated.
  assign w_sum_add = w_sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];
`else
  assign w_sum_add = r_sum + {{(ACC_WIDTH - 32){1'b0}}, score_in};
`endif

  // In IDLE the accumulator is all zero, so the same update rule also loads the first score.
  assign w_gt        = score_valid && (score_in > r_max);
  assign w_new_sum   = score_valid ? w_sum_add : r_sum;
  assign w_new_max   = w_gt ? score_in : r_max;
  assign w_new_arg   = w_gt ? r_count[IDX_WIDTH-1:0] : r_argmax;
  assign w_new_count = score_valid ? r_count + 1'b1 : r_count;

  assign w_commit = (score_valid && (w_new_count == CNT_W'(KEYS_PER_QUERY))) ||
                    (flush && ((r_count != '0) || score_valid));

  assign w_full = (r_entries == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_push = w_commit && (!w_full || w_pop);
  assign w_drop = w_commit && w_full && !w_pop;

  always_comb begin
    w_entries_next = r_entries;
    if (w_push && !w_pop)      w_entries_next = r_entries + 1'b1;
    else if (!w_push && w_pop) w_entries_next = r_entries - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_max    <= '0;
      r_argmax <= '0;
      r_count  <= '0;
    end else if (w_commit) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_max    <= '0;
      r_argmax <= '0;
      r_count  <= '0;
    end else if (score_valid) begin
      r_state  <= S_ACCUM;
      r_sum    <= w_new_sum;
      r_max    <= w_new_max;
      r_argmax <= w_new_arg;
      r_count  <= w_new_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_sum[i] <= '0;
        r_mem_max[i] <= '0;
        r_mem_arg[i] <= '0;
        r_mem_cnt[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_entries  <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_sum[r_wr_ptr] <= w_new_sum;
        r_mem_max[r_wr_ptr] <= w_new_max;
        r_mem_arg[r_wr_ptr] <= w_new_arg;
        r_mem_cnt[r_wr_ptr] <= w_new_count;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_entries <= w_entries_next;
      r_credit  <= (w_entries_next != (PTR_W + 1)'(FIFO_DEPTH));
      // A drop in the same cycle as a clear request leaves the flag set.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign out_valid  = (r_entries != '0);
  assign out_sum    = r_mem_sum[r_rd_ptr];
  assign out_max    = r_mem_max[r_rd_ptr];
  assign out_argmax = r_mem_arg[r_rd_ptr];
  assign out_count  = r_mem_cnt[r_rd_ptr];
  assign credit_ok  = r_credit;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_photon_score_aggregator.sv
// Bench for photon_score_aggregator: table-driven groups, scoreboard on output pops, hand-written corner sequences.
module tb_photon_score_aggregator;
  localparam int ACC = 32;
  localparam int W   = ACC + 32 + 3 + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       score_in = '0;
  logic              score_valid = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC-1:0]    out_sum;
  logic [31:0]       out_max;
  logic [2:0]        out_argmax;
  logic [3:0]        out_count;
  logic              credit_ok;
  logic              overflow;
  logic              clear_overflow = 1'b0;
  logic              dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int n_pops  = 0;
  logic [W-1:0] exp_q[$];

  photon_score_aggregator #(.KEYS_PER_QUERY(8), .ACC_WIDTH(ACC), .FIFO_DEPTH(4), .IDX_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_max(out_max),
    .out_argmax(out_argmax), .out_count(out_count), .credit_ok(credit_ok), .overflow(overflow),
    .clear_overflow(clear_overflow), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0][31:0] sc;
    int               n;
    bit               fl;
    logic [ACC-1:0]   e_sum;
    logic [31:0]      e_max;
    logic [2:0]       e_arg;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [W-1:0] rec(input logic [ACC-1:0] s, input logic [31:0] m,
                                       input logic [2:0] a, input logic [3:0] c);
    return {s, m, a, c};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // scoreboard: compare each accepted head against the oldest expected record
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      got = {out_sum, out_max, out_argmax, out_count};
      n_total++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_record: got sum=%0h max=%0h arg=%0d cnt=%0d, none expected",
                 out_sum, out_max, out_argmax, out_count);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL record: got sum=%0h max=%0h arg=%0d cnt=%0d expected sum=%0h max=%0h arg=%0d cnt=%0d",
                   out_sum, out_max, out_argmax, out_count,
                   e[W-1 -: ACC], e[38:7], e[6:4], e[3:0]);
        end
      end
    end
  end

  // driver: inputs change 1 time unit after the rising edge
  task automatic send(input logic [31:0] s, input bit fl);
    score_valid = 1'b1;
    score_in    = s;
    flush       = fl;
    @(posedge clk); #1;
    score_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic send_group(input logic [7:0][31:0] sc, input int n, input bit fl,
                            input bit exp_en, input logic [W-1:0] e);
    if (exp_en) exp_q.push_back(e);
    for (int i = 0; i < n; i++) send(sc[i], fl && (i == n - 1));
  endtask

  task automatic send_single(input logic [31:0] v, input bit exp_en);
    logic [7:0][31:0] sc;
    sc    = '0;
    sc[0] = v;
    send_group(sc, 1, 1'b1, exp_en, rec(ACC'(v), v, 3'd0, 4'd1));
  endtask

  task automatic wait_drain(input string nm);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d records still outstanding, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int pops_before;
    logic [7:0][31:0] sc;
    logic [ACC-1:0] es;
    logic [31:0] em;
    logic [2:0] ea;
    int n;
    logic [ACC-1:0] sat_exp;

    vecs[0].sc = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[0].n = 8; vecs[0].fl = 0; vecs[0].e_sum = 36;  vecs[0].e_max = 8;  vecs[0].e_arg = 7;
    vecs[1].sc = {32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd9, 32'd9, 32'd5};
    vecs[1].n = 8; vecs[1].fl = 0; vecs[1].e_sum = 25;  vecs[1].e_max = 9;  vecs[1].e_arg = 1;
    vecs[2].sc = {8{32'd7}};
    vecs[2].n = 8; vecs[2].fl = 0; vecs[2].e_sum = 56;  vecs[2].e_max = 7;  vecs[2].e_arg = 0;
    vecs[3].sc = {32'd0, 32'd0, 32'd0, 32'd0, 32'd40, 32'd30, 32'd20, 32'd10};
    vecs[3].n = 4; vecs[3].fl = 1; vecs[3].e_sum = 100; vecs[3].e_max = 40; vecs[3].e_arg = 3;

    // reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_credit_ok", 64'(credit_ok), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_out_sum", 64'(out_sum), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_credit_ok", 64'(credit_ok), 1);
    check("post_rst_state", 64'(dbg_state), 0);
    out_ready = 1'b1;

    // basic group: single-cycle out_valid pulse right after the 8th score
    send_group(vecs[0].sc, vecs[0].n, vecs[0].fl, 1'b1,
               rec(vecs[0].e_sum, vecs[0].e_max, vecs[0].e_arg, 4'(vecs[0].n)));
    check("basic_valid", 64'(out_valid), 1);
    @(posedge clk); #1;
    check("basic_pulse", 64'(out_valid), 0);

    // remaining table entries back-to-back (tie A, group B, flush with score)
    for (int i = 1; i < 4; i++)
      send_group(vecs[i].sc, vecs[i].n, vecs[i].fl, 1'b1,
                 rec(vecs[i].e_sum, vecs[i].e_max, vecs[i].e_arg, 4'(vecs[i].n)));

    // flush while idle is a no-op
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain("table_drain");
    check("idle_flush_no_record", 64'(out_valid), 0);

    // random groups against a small reference model
    for (int g = 0; g < 8; g++) begin
      n  = $urandom_range(2, 8);
      sc = '0;
      es = '0; em = '0; ea = '0;
      for (int i = 0; i < n; i++) begin
        sc[i] = $urandom_range(0, 20);
        es = es + sc[i];
        if (i == 0 || sc[i] > em) begin
          em = sc[i];
          ea = 3'(i);
        end
      end
      send_group(sc, n, n < 8, 1'b1, rec(es, em, ea, 4'(n)));
    end
    wait_drain("random_drain");

    // backpressure and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_single(32'(100 + i), 1'b1);
    check("ovf_credit_after3", 64'(credit_ok), 1);
    send_single(32'd103, 1'b1);
    check("ovf_credit_after4", 64'(credit_ok), 0);
    send_single(32'd104, 1'b0);
    check("ovf_flag_set", 64'(overflow), 1);
    check("ovf_credit_still0", 64'(credit_ok), 0);
    pops_before = n_pops;
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_drain_count", 64'(n_pops - pops_before), 4);
    check("ovf_drain_empty", 64'(out_valid), 0);
    check("ovf_sticky", 64'(overflow), 1);
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 0);

    // full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_single(32'(200 + i), 1'b1);
    check("pp_full", 64'(credit_ok), 0);
    pops_before = n_pops;
    exp_q.push_back(rec(ACC'(77), 32'd77, 3'd0, 4'd1));
    out_ready   = 1'b1;
    score_valid = 1'b1;
    score_in    = 32'd77;
    flush       = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    check("pp_occupancy", 64'(credit_ok), 0);
    check("pp_no_drop", 64'(overflow), 0);
    out_ready = 1'b1;
    wait_drain("pp_drain");
    check("pp_drain_count", 64'(n_pops - pops_before), 5);

    // saturation / wrap with 8 x all-ones
`ifdef PHOTON_AGG_SATURATE_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'hFFFF_FFF8;
`endif
    sc = {8{32'hFFFF_FFFF}};
    send_group(sc, 8, 1'b0, 1'b1, rec(sat_exp, 32'hFFFF_FFFF, 3'd0, 4'd8));
    wait_drain("sat_drain");

    // reset mid-group discards the partial group
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    send(32'd70, 1'b0);
    check("mid_state_accum", 64'(dbg_state), 1);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_out_sum", 64'(out_sum), 0);
    check("midrst_out_max", 64'(out_max), 0);
    check("midrst_out_argmax", 64'(out_argmax), 0);
    check("midrst_out_count", 64'(out_count), 0);
    check("midrst_credit_ok", 64'(credit_ok), 0);
    check("midrst_overflow", 64'(overflow), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_single(32'd3, 1'b1);
    check("postrst_valid", 64'(out_valid), 1);
    wait_drain("postrst_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
